// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
// State encoding, nibble width and a parameter sanity check.
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_e;

    // A legal width is a whole number of nibbles, at least one.
    function automatic bit width_ok(input int w);
        return (w >= NIBBLE_W) && ((w % NIBBLE_W) == 0);
    endfunction

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// Four-bit ripple-carry adder built from single-bit full adders.
// Purely combinational; the sequencing lives in the parent.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

module ripple_carry_adder_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [4:0] c;

    assign c[0]   = cin_i;
    assign cout_o = c[4];

    for (genvar i = 0; i < 4; i++) begin : g_fa
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (c[i]),
            .s_o (sum_o[i]),
            .c_o (c[i+1])
        );
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder reusing one 4-bit adder, LSB nibble first.
// Valid/ready on both sides; one bubble cycle between operations.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4, >= 4");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_nx;
    logic             c_q, c_d;
    logic             am_q, am_d;
    logic             bm_q, bm_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       nib_sum;
    logic             nib_co;

    ripple_carry_adder_4bit u_rca (
        .a_i    (a_q[NIBBLE_W-1:0]),
        .b_i    (b_q[NIBBLE_W-1:0]),
        .cin_i  (c_q),
        .sum_o  (nib_sum),
        .cout_o (nib_co)
    );

    // New nibble enters the result from the top, so after NIBBLES
    // shifts the first nibble has reached bit 0.
    if (WIDTH == NIBBLE_W) begin : g_one_nib
        assign res_nx = nib_sum;
    end else begin : g_multi_nib
        assign res_nx = {nib_sum, res_q[WIDTH-1:NIBBLE_W]};
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = res_q;
    assign cout      = c_q;
    assign overflow  = (am_q == bm_q) && (res_q[WIDTH-1] != am_q);

    // Next-state and datapath sequencing for IDLE -> RUN -> DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        c_d     = c_q;
        am_d    = am_q;
        bm_d    = bm_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    c_d     = cin;
                    am_d    = a[WIDTH-1];
                    bm_d    = b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d = res_nx;
                a_d   = a_q >> NIBBLE_W;
                b_d   = b_q >> NIBBLE_W;
                c_d   = nib_co;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, operand, carry and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
            am_q    <= 1'b0;
            bm_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            c_q     <= c_d;
            am_q    <= am_d;
            bm_q    <= bm_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder at WIDTH=16 and WIDTH=4.
// Stimulus pushes expected results; monitors pop on each transfer.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv, ir, ov, ordy, cin, co, ovf;
    logic [15:0] a, b, s;
    logic        iv4, ir4, ov4, ordy4, cin4, co4, ovf4;
    logic [3:0]  a4, b4, s4;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
    } exp_t;

    exp_t q16[$];
    exp_t q4[$];
    int   total = 0;
    int   bad   = 0;
    int   n_in16 = 0, n_out16 = 0;
    int   n_in4 = 0, n_out4 = 0;
    bit   done_rnd = 0;

    nibble_serial_adder #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv),
        .in_ready  (ir),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (ov),
        .out_ready (ordy),
        .sum       (s),
        .cout      (co),
        .overflow  (ovf)
    );

    nibble_serial_adder #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (ov4),
        .out_ready (ordy4),
        .sum       (s4),
        .cout      (co4),
        .overflow  (ovf4)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] sv, input logic c,
                                input logic v);
        exp_t e;
        e.s = sv;
        e.c = c;
        e.v = v;
        return e;
    endfunction

    // Reference: plain integer addition, signed overflow from sign bits.
    function automatic exp_t model(input int w, input logic [15:0] x,
                                   input logic [15:0] y, input logic c);
        logic [16:0] t;
        logic [16:0] m;
        exp_t        e;
        m   = (17'd1 << w) - 17'd1;
        t   = 17'(x) + 17'(y) + 17'(c);
        e.s = 16'(t & m);
        e.c = t[w];
        e.v = (x[w-1] == y[w-1]) && (t[w-1] != x[w-1]);
        return e;
    endfunction

    task automatic issue16(input logic [15:0] x, input logic [15:0] y,
                           input logic c, input exp_t e);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        a   = x;
        b   = y;
        cin = c;
        iv  = 1'b1;
        forever begin
            @(negedge clk);
            if (ir) break;
            n++;
            if (n > 200) break;
        end
        chk("accept16", ir, 1);
        if (ir) begin
            q16.push_back(e);
            n_in16++;
        end
        @(posedge clk);
        #1;
        iv = 1'b0;
    endtask

    task automatic issue4(input logic [3:0] x, input logic [3:0] y,
                          input logic c, input exp_t e);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        a4   = x;
        b4   = y;
        cin4 = c;
        iv4  = 1'b1;
        forever begin
            @(negedge clk);
            if (ir4) break;
            n++;
            if (n > 200) break;
        end
        chk("accept4", ir4, 1);
        if (ir4) begin
            q4.push_back(e);
            n_in4++;
        end
        @(posedge clk);
        #1;
        iv4 = 1'b0;
    endtask

    // Monitor for the 16-bit instance: compare on every transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov && ordy) begin
            n_out16++;
            if (q16.size() == 0) begin
                chk("unexpected16", n_out16, n_in16);
            end else begin
                e = q16.pop_front();
                chk("sum16", 32'(s), 32'(e.s));
                chk("cout16", co, e.c);
                chk("ovf16", ovf, e.v);
            end
        end
    end

    // Monitor for the 4-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ov4 && ordy4) begin
            n_out4++;
            if (q4.size() == 0) begin
                chk("unexpected4", n_out4, n_in4);
            end else begin
                e = q4.pop_front();
                chk("sum4", 32'(s4), 32'(e.s));
                chk("cout4", co4, e.c);
                chk("ovf4", ovf4, e.v);
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] x, y;
        logic        c;

        rst_n = 1'b0;
        iv    = 1'b0;
        ordy  = 1'b1;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        iv4   = 1'b0;
        ordy4 = 1'b1;
        a4    = '0;
        b4    = '0;
        cin4  = 1'b0;
        #12;
        chk("rst_in_ready", ir, 0);
        chk("rst_out_valid", ov, 0);
        chk("rst_sum", 32'(s), 0);
        chk("rst_cout", co, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", ir, 1);

        issue16(16'h1234, 16'h4321, 1'b1, mk(16'h5556, 1'b0, 1'b0));
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov) break;
            lat++;
        end
        chk("latency16", lat, 4);

        issue16(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1'b1, 1'b0));
        issue16(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        issue16(16'h8000, 16'h8000, 1'b0, mk(16'h0000, 1'b1, 1'b1));

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ir) break;
        end
        ordy = 1'b0;
        issue16(16'h1111, 16'h2222, 1'b0, mk(16'h3333, 1'b0, 1'b0));
        a  = 16'hAAAA;
        b  = 16'h5555;
        iv = 1'b1;
        @(posedge clk);
        #1;
        iv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ov) break;
        end
        chk("bp_valid", ov, 1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_sum", 32'(s), 32'h3333);
            chk("bp_cout", co, 0);
            chk("bp_ovf", ovf, 0);
            chk("bp_in_ready", ir, 0);
            chk("bp_hold_valid", ov, 1);
        end
        @(posedge clk);
        #1;
        ordy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", ir, 1);

        issue16(16'h1357, 16'h2468, 1'b0, mk(16'h37BF, 1'b0, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", 32'(s), 0);
        chk("mid_rst_cout", co, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_valid", ov, 0);
        chk("mid_rst_in_ready", ir, 0);
        n_in16 -= q16.size();
        q16.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", ir, 1);
        issue16(16'h0F0F, 16'hF0F1, 1'b0, mk(16'h0000, 1'b1, 1'b0));

        fork
            begin
                fork
                    begin
                        for (int i = 0; i < 1000; i++) begin
                            x = 16'($urandom);
                            y = 16'($urandom);
                            c = 1'($urandom_range(0, 1));
                            issue16(x, y, c, model(16, x, y, c));
                        end
                    end
                    begin
                        issue4(4'hF, 4'h1, 1'b0, mk(16'h0, 1'b1, 1'b0));
                        issue4(4'h7, 4'h1, 1'b0, mk(16'h8, 1'b0, 1'b1));
                        issue4(4'h8, 4'h8, 1'b0, mk(16'h0, 1'b1, 1'b1));
                        issue4(4'h3, 4'h4, 1'b1, mk(16'h8, 1'b0, 1'b1));
                        for (int i = 0; i < 1000; i++) begin
                            logic [3:0] p, r;
                            logic       k;
                            p = 4'($urandom);
                            r = 4'($urandom);
                            k = 1'($urandom_range(0, 1));
                            issue4(p, r, k, model(4, 16'(p), 16'(r), k));
                        end
                    end
                join
                done_rnd = 1'b1;
            end
            begin
                while (!done_rnd) begin
                    @(posedge clk);
                    #2;
                    ordy  = ($urandom_range(0, 3) != 0);
                    ordy4 = ($urandom_range(0, 3) != 0);
                end
            end
        join

        ordy  = 1'b1;
        ordy4 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (q16.size() == 0 && q4.size() == 0) break;
        end
        chk("drain16", q16.size(), 0);
        chk("drain4", q4.size(), 0);
        chk("count16", n_out16, n_in16);
        chk("count4", n_out4, n_in4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle WIDTH-bit adder. It reuses one ripple_carry_adder_4bit instance, one nibble per clock, least-significant nibble first. It sits directly around that adder: it registers and sequences operands into it, then collects its sum/carry outputs into a full-width result. Upstream and downstream sides use valid/ready handshakes, so the block drops into operand and result pipelines for wide arithmetic without a full-width adder.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise).
NIBBLES, WIDTH/4, derived localparam; number of RUN cycles per operation.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand set a/b/cin is valid.
in_ready  output  1  block can accept operands (IDLE only).
a  input  WIDTH  operand A (unsigned or two's complement).
b  input  WIDTH  operand B.
cin  input  1  carry-in to nibble 0.
out_valid  output  1  result valid (DONE only).
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  a + b + cin, mod 2^WIDTH.
cout  output  1  carry out of bit WIDTH-1.
overflow  output  1  signed overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB].

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. While low: state=IDLE, counter=0, all data registers 0, in_ready=0, out_valid=0, sum=0, cout=0, overflow=0.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid&&in_ready at an edge: latch a, b, cin, a[MSB], b[MSB]; clear counter; go to RUN.
  - RUN: in_ready=0, out_valid=0. The adder gets the low nibble of the A and B shift registers plus the carry register. Each edge:
    - adder sum nibble is shifted into the result register from the top;
    - A and B registers shift right by 4;
    - carry register <= adder Cout;
    - counter++.
    - After the edge where counter==NIBBLES-1, go to DONE.
  - DONE: out_valid=1. sum, cout (final carry register) and overflow are stable and held. When out_valid&&out_ready at an edge, go to IDLE. in_ready=0 in DONE: no same-cycle accept, so one bubble cycle per op.
- Latency: operands accepted at edge E0; out_valid is high after edge E0+NIBBLES. Minimum initiation interval is NIBBLES+2 cycles.
- Boundary conditions:
  - in_valid during RUN/DONE: ignored; operands are not sampled.
  - out_ready held low: DONE persists indefinitely and outputs do not change.
  - out_ready high before DONE: no effect.
  - WIDTH=4: one RUN cycle.
  - Carry wrap-around: cout=1 and sum wraps mod 2^WIDTH; no saturation.
  - rst_n asserted mid-RUN or in DONE: operation aborted, result discarded, reset values applied immediately. After release: IDLE, in_ready=1.
- sum, cout and overflow are driven from registers; no combinational path from inputs to outputs. in_ready and out_valid are decoded from state.

Decomposition:
- Shared arithmetic package:
  - state encoding constants ST_IDLE/ST_RUN/ST_DONE (2 bits);
  - NIBBLE_W=4;
  - a width-check helper for WIDTH%4.
- Sub-module: one ripple_carry_adder_4bit instance (existing block, unchanged; itself built from full_adder).
- Control FSM, counter and shift registers stay in this module.

Test Plan:
- WIDTH=16, a=0x1234, b=0x4321, cin=1 -> out_valid exactly 4 cycles after accept edge; sum=0x5556, cout=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, overflow=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> sum/cout/overflow constant, in_ready=0. Pulse in_valid with a=0xAAAA during RUN -> ignored. Result released on the first out_ready=1 edge; in_ready=1 the following cycle.
- Reset: assert rst_n=0 asynchronously mid-RUN (after 2 nibbles) -> outputs 0 without a clock edge. After release, new op 0x0F0F+0xF0F1 -> sum=0x0000, cout=1.
- Random 1000 back-to-back ops with random out_ready stalls, WIDTH=16 and WIDTH=4 -> every result matches a reference model; no lost or duplicated transfers.
